if_fetch: RTL and testbench

//  Instruction-fetch stage feeding IF_ID, and through it ID. Generates the PC, requests 32-bit

---
 rtl/if_fetch_pkg.sv | 25 ++
 rtl/if_fetch_bht.sv | 35 +++
 rtl/if_fetch.sv | 191 +++++++++++++++++++
 tb/tb_if_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Build option: BHT_PREDICT_EN enables the branch history table.
package if_fetch_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned OPC_W         = 7;
    localparam int unsigned BHT_IDX_W_DEF = 6;

    localparam logic [XLEN-1:0]  NOP          = 32'h0000_0013;
    localparam logic [XLEN-1:0]  RESET_PC_DEF = 32'h0000_0000;
    localparam logic [OPC_W-1:0] OP_JAL       = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_BRANCH    = 7'b1100011;

    // Legacy-compatible FSM encodings
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0] npc;
        logic            pred;
    } next_pc_t;

endpackage

// File: rtl/if_fetch_bht.sv
// Branch history table: 2-bit saturating counters, async read, clocked update.
module if_fetch_bht #(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr_c,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0] ctr [DEPTH];

    // A same-cycle lookup sees the pre-update value
    assign rd_ctr_c = ctr[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr[IDX_W'(i)] <= 2'b01;
            end
        end else if (wr_en) begin
            if (wr_taken && (ctr[wr_idx] != 2'b11)) begin
                ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
            end else if (!wr_taken && (ctr[wr_idx] != 2'b00)) begin
                ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC generation, memory request handshake, static/BHT prediction.
// Build option: BHT_PREDICT_EN enables BHT-based prediction of conditional branches.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned BHT_IDX_W = BHT_IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        bht_upd,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_taken,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_pred
);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] hold_npc;
    logic            issue;
    logic            take_word;
    logic            hold_word;
    logic            release_word;
    logic            pred_bxx;
    logic [OPC_W-1:0] opcode;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_b;
    next_pc_t        nxt;

`ifdef BHT_PREDICT_EN
    logic [1:0] bht_ctr;
    logic       unused_bht;

    if_fetch_bht #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc[BHT_IDX_W+1:2]),
        .rd_ctr_c (bht_ctr),
        .wr_en    (bht_upd),
        .wr_idx   (bht_upd_pc[BHT_IDX_W+1:2]),
        .wr_taken (bht_taken)
    );

    assign pred_bxx   = bht_ctr[1];
    assign unused_bht = ^bht_upd_pc;
`else
    logic unused_bht;

    assign pred_bxx   = 1'b0;
    assign unused_bht = ^{bht_upd, bht_upd_pc, bht_taken};
`endif

    // Next-PC prediction from the word arriving this cycle
    always_comb begin
        opcode   = mem_inst[6:0];
        imm_j    = {{12{mem_inst[31]}}, mem_inst[19:12], mem_inst[20], mem_inst[30:21], 1'b0};
        imm_b    = {{20{mem_inst[31]}}, mem_inst[7], mem_inst[30:25], mem_inst[11:8], 1'b0};
        nxt.npc  = pc + 32'd4;
        nxt.pred = 1'b0;
        if (opcode == OP_JAL) begin
            nxt.npc  = pc + imm_j;
            nxt.pred = 1'b1;
        end else if ((opcode == OP_BRANCH) && pred_bxx) begin
            nxt.npc  = pc + imm_b;
            nxt.pred = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush overrides every other transition
    always_comb begin
        state_nxt    = state;
        issue        = 1'b0;
        take_word    = 1'b0;
        hold_word    = 1'b0;
        release_word = 1'b0;
        if (flush) begin
            if ((state == ST_WAIT) || (state == ST_DRAIN)) begin
                state_nxt = mem_done ? ST_FETCH : ST_DRAIN;
            end else begin
                state_nxt = ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    state_nxt = ST_WAIT;
                    issue     = 1'b1;
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        if (stall) begin
                            state_nxt = ST_HOLD;
                            hold_word = 1'b1;
                        end else begin
                            take_word = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_nxt    = ST_FETCH;
                        release_word = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (mem_done) begin
                        state_nxt = ST_FETCH;
                    end
                end
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            hold_npc  <= RESET_PC;
            mem_req   <= 1'b0;
            mem_addr  <= {RESET_PC[31:2], 2'b00};
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= NOP;
            out_pred  <= 1'b0;
        end else if (flush) begin
            pc        <= flush_pc;
            mem_req   <= ((state == ST_WAIT) || (state == ST_DRAIN)) && !mem_done;
            out_valid <= 1'b0;
            out_inst  <= NOP;
            out_pred  <= 1'b0;
        end else begin
            // Presentation lasts one cycle except while holding a stalled word
            if (state != ST_HOLD) begin
                out_valid <= 1'b0;
                out_inst  <= NOP;
                out_pred  <= 1'b0;
            end
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= {pc[31:2], 2'b00};
            end
            if (take_word) begin
                pc        <= nxt.npc;
                mem_req   <= 1'b1;
                mem_addr  <= {nxt.npc[31:2], 2'b00};
                out_valid <= 1'b1;
                out_pc    <= pc;
                out_inst  <= mem_inst;
                out_pred  <= nxt.pred;
            end
            if (hold_word) begin
                hold_npc  <= nxt.npc;
                mem_req   <= 1'b0;
                out_valid <= 1'b1;
                out_pc    <= pc;
                out_inst  <= mem_inst;
                out_pred  <= nxt.pred;
            end
            if (release_word) begin
                pc        <= hold_npc;
                out_valid <= 1'b0;
                out_inst  <= NOP;
                out_pred  <= 1'b0;
            end
            if ((state == ST_DRAIN) && mem_done) begin
                mem_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: straight line, stall hold, JAL, flush, branch prediction, reset.
module tb_if_fetch;

    localparam logic [31:0] NOP_W  = 32'h0000_0013;
    localparam logic [31:0] ADDI_W = 32'h0010_8093;
    localparam logic [31:0] JAL_16 = 32'h0100_006F;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        bht_upd;
    logic [31:0] bht_upd_pc;
    logic        bht_taken;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_inst;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .bht_upd    (bht_upd),
        .bht_upd_pc (bht_upd_pc),
        .bht_taken  (bht_taken),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_inst   (mem_inst),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_pred   (out_pred)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (mem_req === 1'b1) break;
            tick();
        end
        chk("mem_req_timeout", 32'(mem_req), 32'd1);
    endtask

    // Memory returns inst lat cycles after the request is first seen
    task automatic serve(input logic [31:0] inst, input int lat);
        for (int i = 1; i < lat; i++) tick();
        mem_done = 1'b1;
        mem_inst = inst;
        tick();
        mem_done = 1'b0;
    endtask

    logic        exp_pred;
    logic [31:0] exp_addr;

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
        bht_upd = 1'b0; bht_upd_pc = '0; bht_taken = 1'b0;
        mem_done = 1'b0; mem_inst = '0;
        tick(); tick();

        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, NOP_W);
        chk("rst_out_pred", 32'(out_pred), 32'd0);
        rst = 1'b1;

        // Straight line, 3-cycle memory latency
        wait_req();
        chk("t1_addr0", mem_addr, 32'h0);
        serve(ADDI_W, 3);
        chk("t1_valid0", 32'(out_valid), 32'd1);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_inst0", out_inst, ADDI_W);
        chk("t1_pred0", 32'(out_pred), 32'd0);
        chk("t1_addr4", mem_addr, 32'h4);
        wait_req();
        serve(ADDI_W, 3);
        chk("t1_pc4", out_pc, 32'h4);
        chk("t1_addr8", mem_addr, 32'h8);
        wait_req();
        serve(ADDI_W, 3);
        chk("t1_pc8", out_pc, 32'h8);
        chk("t1_pred8", 32'(out_pred), 32'd0);
        chk("t1_addrC", mem_addr, 32'hC);
        tick();
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // Stall while the word at 0xC arrives
        stall = 1'b1;
        mem_done = 1'b1;
        mem_inst = ADDI_W;
        tick();
        mem_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_pc", out_pc, 32'hC);
            chk("t2_hold_inst", out_inst, ADDI_W);
            chk("t2_no_req", 32'(mem_req), 32'd0);
            if (i == 4) stall = 1'b0;
            tick();
        end
        chk("t2_consumed", 32'(out_valid), 32'd0);
        chk("t2_req_idle", 32'(mem_req), 32'd0);
        tick();
        chk("t2_req", 32'(mem_req), 32'd1);
        chk("t2_addr10", mem_addr, 32'h10);

        // Walk to 0x20, then JAL +16
        for (int i = 0; i < 4; i++) begin
            wait_req();
            chk("t3_walk_addr", mem_addr, 32'h10 + 32'(i * 4));
            serve(ADDI_W, 1);
        end
        wait_req();
        chk("t3_addr20", mem_addr, 32'h20);
        serve(JAL_16, 1);
        chk("t3_pc", out_pc, 32'h20);
        chk("t3_pred", 32'(out_pred), 32'd1);
        chk("t3_addr30", mem_addr, 32'h30);

        // Flush during WAIT, memory answers two cycles later
        flush = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_drain_req", 32'(mem_req), 32'd1);
        chk("t4_drain_addr", mem_addr, 32'h30);
        tick();
        serve(ADDI_W, 1);
        chk("t4_discard", 32'(out_valid), 32'd0);
        chk("t4_req_off", 32'(mem_req), 32'd0);
        tick();
        chk("t4_req", 32'(mem_req), 32'd1);
        chk("t4_addr100", mem_addr, 32'h100);

        // Flush coincident with mem_done, then train BHT and fetch BEQ -8
        flush = 1'b1;
        flush_pc = 32'h40;
        mem_done = 1'b1;
        mem_inst = ADDI_W;
        tick();
        flush = 1'b0;
        mem_done = 1'b0;
        chk("t5_drop_valid", 32'(out_valid), 32'd0);
        chk("t5_drop_req", 32'(mem_req), 32'd0);
        bht_upd = 1'b1;
        bht_upd_pc = 32'h40;
        bht_taken = 1'b1;
        tick();
        tick();
        bht_upd = 1'b0;
        bht_taken = 1'b0;
        wait_req();
        chk("t5_addr40", mem_addr, 32'h40);
        serve(BEQ_M8, 1);
`ifdef BHT_PREDICT_EN
        exp_pred = 1'b1;
        exp_addr = 32'h38;
`else
        exp_pred = 1'b0;
        exp_addr = 32'h44;
`endif
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_pc", out_pc, 32'h40);
        chk("t5_pred", 32'(out_pred), 32'(exp_pred));
        chk("t5_next_addr", mem_addr, exp_addr);

        // Asynchronous reset mid-request
        rst = 1'b0;
        #1;
        chk("t6_req_drop", 32'(mem_req), 32'd0);
        chk("t6_valid_drop", 32'(out_valid), 32'd0);
        chk("t6_inst_nop", out_inst, NOP_W);
        tick();
        rst = 1'b1;
        wait_req();
        chk("t6_addr_reset", mem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
